data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 24 ++
 rtl/data_mem_responder_word_array.sv | 31 +++
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data_mem_responder slice.
// Build option DMEM_ALIGN_CHECK_EN is consumed by data_mem_responder.sv.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int BE_WIDTH            = 4;
   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_WAIT_CYCLES = 2;

   function automatic logic [31:0] be_to_mask(input logic [BE_WIDTH-1:0] be);
      logic [31:0] mask;
      mask = 32'h0000_0000;
      for (int i = 0; i < BE_WIDTH; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/data_mem_responder_word_array.sv
// dmem_word_array: word storage with byte-enabled synchronous write and one
// asynchronous read port. Deliberately has no reset so contents survive it.
module dmem_word_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [31:0]         wdata,
   input  logic [BE_WIDTH-1:0] be,
   output logic [31:0]         rdata
);

   logic [31:0] mem_r [DEPTH_WORDS];
   logic [31:0] mask_s;

   assign mask_s = be_to_mask(be);

   // Merge the enabled bytes into the addressed word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[addr] <= (mem_r[addr] & ~mask_s) | (wdata & mask_s);
      end
   end

   assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with configurable wait states.
// Define DMEM_ALIGN_CHECK_EN to reject byte addresses that are not word aligned.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   input  logic [BE_WIDTH-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_err
);

   localparam int         ADDR_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic ALIGN_CHECK = 1'b1;
`else
   localparam logic ALIGN_CHECK = 1'b0;
`endif

   state_t              state_r, state_s;
   logic [3:0]          wait_cnt_r, wait_cnt_s;
   logic                cap_write_r;
   logic [31:0]         cap_addr_r, cap_wdata_r;
   logic [BE_WIDTH-1:0] cap_be_r;
   logic                accept_s, commit_s;
   logic                cur_write_s;
   logic [31:0]         cur_addr_s, cur_wdata_s;
   logic [BE_WIDTH-1:0] cur_be_s;
   logic                range_err_s, align_err_s, err_s;
   logic [31:0]         mem_rdata_s;

   assign req_ready = (state_r == IDLE);
   assign rsp_valid = (state_r == RESP);
   assign accept_s  = req_valid && (state_r == IDLE);
   assign commit_s  = (state_r != RESP) && (state_s == RESP);

   // With zero wait states the commit edge is the acceptance edge, so the
   // live request is used in IDLE and the captured copy afterwards.
   always_comb begin
      cur_write_s = cap_write_r;
      cur_addr_s  = cap_addr_r;
      cur_wdata_s = cap_wdata_r;
      cur_be_s    = cap_be_r;
      if (state_r == IDLE) begin
         cur_write_s = req_write;
         cur_addr_s  = req_addr;
         cur_wdata_s = req_wdata;
         cur_be_s    = req_be;
      end else begin
         cur_write_s = cap_write_r;
      end
   end

   assign range_err_s = ({2'b00, cur_addr_s[31:2]} >= 32'(DEPTH_WORDS));
   assign align_err_s = ALIGN_CHECK & (cur_addr_s[1:0] != 2'b00);
   assign err_s       = range_err_s | align_err_s;

   // FSM state and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         wait_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
      end
   end

   // Next-state and wait-count decode.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      case (state_r)
         IDLE: begin
            wait_cnt_s = 4'd0;
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (wait_cnt_r == LAST_WAIT) begin
               state_s    = RESP;
               wait_cnt_s = 4'd0;
            end else begin
               wait_cnt_s = wait_cnt_r + 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s    = IDLE;
            wait_cnt_s = 4'd0;
         end
      endcase
   end

   // Request capture and registered response fields.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_write_r <= 1'b0;
         cap_addr_r  <= 32'h0000_0000;
         cap_wdata_r <= 32'h0000_0000;
         cap_be_r    <= {BE_WIDTH{1'b0}};
         rsp_rdata   <= 32'h0000_0000;
         rsp_err     <= 1'b0;
      end else begin
         if (accept_s) begin
            cap_write_r <= req_write;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cap_be_r    <= req_be;
         end
         if (commit_s) begin
            rsp_err   <= err_s;
            rsp_rdata <= (cur_write_s || err_s) ? 32'h0000_0000 : mem_rdata_s;
         end else if ((state_r == RESP) && rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
         end
      end
   end

   dmem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_array (
      .clk   (clk),
      .wr_en (commit_s & cur_write_s & ~err_s),
      .addr  (cur_addr_s[ADDR_W+1:2]),
      .wdata (cur_wdata_s),
      .be    (cur_be_s),
      .rdata (mem_rdata_s)
   );

endmodule
